// File: rtl/saradc_sar_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : saradc_sar_ctrl
// Brief    : SAR conversion controller - sample switch, cap-DAC bit trials,
//            comparator trigger/ready handshake, timeout and abort handling.
// Revision : 1.0
// ============================================================================
module saradc_sar_ctrl #(
  parameter int NBITS   = 8,
  parameter int SCW     = 4,
  parameter int TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic             abort,
  input  logic [SCW-1:0]   sample_cycles,
  input  logic             comp_out,
  input  logic             comp_rdy,
  output logic             sample,
  output logic             comp_trig,
  output logic [NBITS-1:0] dac_sel,
  output logic             busy,
  output logic [NBITS-1:0] result,
  output logic             result_valid,
  output logic             timeout_err
);

  localparam int c_IDX_W  = $clog2(NBITS);
  localparam int c_WCNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SAMPLE = 3'd1,
    S_TRIG   = 3'd2,
    S_WAIT   = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t               r_state, w_state;
  logic [SCW-1:0]       r_scnt, w_scnt, w_sc_load;
  logic [c_WCNT_W-1:0]  r_wcnt, w_wcnt;
  logic [c_IDX_W-1:0]   r_idx, w_idx, w_idx_m1;
  logic [NBITS-1:0]     w_dac, w_result;
  logic                 w_rv, w_terr, w_sample, w_trig, w_busy;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state      <= S_IDLE;
      r_scnt       <= '0;
      r_wcnt       <= '0;
      r_idx        <= '0;
      sample       <= 1'b0;
      comp_trig    <= 1'b0;
      dac_sel      <= '0;
      busy         <= 1'b0;
      result       <= '0;
      result_valid <= 1'b0;
      timeout_err  <= 1'b0;
    end else begin
      r_state      <= w_state;
      r_scnt       <= w_scnt;
      r_wcnt       <= w_wcnt;
      r_idx        <= w_idx;
      sample       <= w_sample;
      comp_trig    <= w_trig;
      dac_sel      <= w_dac;
      busy         <= w_busy;
      result       <= w_result;
      result_valid <= w_rv;
      timeout_err  <= w_terr;
    end
  end

  always_comb begin
    w_state   = r_state;
    w_scnt    = r_scnt;
    w_wcnt    = r_wcnt;
    w_idx     = r_idx;
    w_idx_m1  = r_idx - 1'b1;
    w_dac     = dac_sel;
    w_result  = result;
    w_rv      = 1'b0;
    w_terr    = timeout_err;
    w_sc_load = (sample_cycles == '0) ? SCW'(1) : sample_cycles;

    case (r_state)
      S_IDLE, S_DONE: begin
        w_dac = '0;
        if (start) begin
          w_state = S_SAMPLE;
          w_scnt  = w_sc_load;
          w_terr  = 1'b0;
        end else begin
          w_state = S_IDLE;
        end
      end
      S_SAMPLE: begin
        if (r_scnt <= SCW'(1)) begin
          w_state            = S_TRIG;
          w_dac              = '0;
          w_dac[NBITS-1]     = 1'b1;
          w_idx              = c_IDX_W'(NBITS - 1);
        end else begin
          w_scnt = r_scnt - 1'b1;
        end
      end
      S_TRIG: begin
        w_state = S_WAIT;
        w_wcnt  = c_WCNT_W'(1);
      end
      S_WAIT: begin
        // A missing ready at the timeout limit is decided as "vin below DAC".
        if (comp_rdy || (r_wcnt >= c_WCNT_W'(TIMEOUT))) begin
          w_dac[r_idx] = comp_rdy & comp_out;
          if (!comp_rdy) begin
            w_terr = 1'b1;
          end
          if (r_idx != '0) begin
            w_dac[w_idx_m1] = 1'b1;
            w_idx           = w_idx_m1;
            w_state         = S_TRIG;
          end else begin
            w_result = w_dac;
            w_rv     = 1'b1;
            w_dac    = '0;
            w_state  = S_DONE;
          end
        end else begin
          w_wcnt = r_wcnt + 1'b1;
        end
      end
      default: w_state = S_IDLE;
    endcase

    if (abort) begin
      w_state  = S_IDLE;
      w_dac    = '0;
      w_rv     = 1'b0;
      w_result = result;
      w_terr   = timeout_err;
    end

    w_sample = (w_state == S_SAMPLE);
    w_trig   = (w_state == S_TRIG);
    w_busy   = (w_state == S_SAMPLE) || (w_state == S_TRIG) || (w_state == S_WAIT);
  end

endmodule
`default_nettype wire

// File: tb/tb_saradc_sar_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_saradc_sar_ctrl
// Brief    : Directed self-checking bench for saradc_sar_ctrl (NBITS=8).
// Revision : 1.0
// ============================================================================
module tb_saradc_sar_ctrl;

  logic       clk = 1'b0;
  logic       rstn, start, abort;
  logic [3:0] sample_cycles;
  logic       comp_out, comp_rdy;
  logic       sample, comp_trig, busy, result_valid, timeout_err;
  logic [7:0] dac_sel, result;

  logic [7:0] vin;
  logic       rdy_en, hold_msb;

  int checks   = 0;
  int failures = 0;
  int rv_edge, nsamp, ntrig;
  logic       te_after;
  logic [7:0] trial [0:15];
  int         trig_edge [0:15];

  always #5 clk = ~clk;

  // Ideal comparator: ready in the first WAIT cycle, optionally silent on the MSB trial.
  assign comp_out = (vin >= dac_sel);
  assign comp_rdy = rdy_en && !(hold_msb && (dac_sel == 8'h80));

  saradc_sar_ctrl #(.NBITS(8), .SCW(4), .TIMEOUT(15)) dut (
    .clk(clk), .rstn(rstn), .start(start), .abort(abort),
    .sample_cycles(sample_cycles), .comp_out(comp_out), .comp_rdy(comp_rdy),
    .sample(sample), .comp_trig(comp_trig), .dac_sel(dac_sel), .busy(busy),
    .result(result), .result_valid(result_valid), .timeout_err(timeout_err)
  );

  task automatic run_conv(input logic [7:0] v, input logic [3:0] sc, input bit hold_start);
    vin = v;
    sample_cycles = sc;
    rv_edge = -1;
    ntrig = 0;
    for (int k = 0; k < 16; k++) begin
      trial[k] = 8'h00;
      trig_edge[k] = -1;
    end
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1;
    if (!hold_start) start = 1'b0;
    nsamp = sample ? 1 : 0;
    te_after = timeout_err;
    for (int e = 1; e <= 200 && rv_edge < 0; e++) begin
      @(posedge clk); #1;
      if (sample) nsamp++;
      if (comp_trig) begin
        if (ntrig < 16) begin
          trial[ntrig] = dac_sel;
          trig_edge[ntrig] = e;
        end
        ntrig++;
      end
      if (result_valid) rv_edge = e;
    end
  endtask

  task automatic test_reset;
    rstn = 1'b0; start = 1'b0; abort = 1'b0; sample_cycles = 4'd2;
    vin = 8'h00; rdy_en = 1'b1; hold_msb = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({sample, comp_trig, busy, result_valid, timeout_err} !== 5'b0) begin
      failures++;
      $display("FAIL reset_flags got=%b exp=00000", {sample, comp_trig, busy, result_valid, timeout_err});
    end
    checks++;
    if ({dac_sel, result} !== 16'h0000) begin
      failures++;
      $display("FAIL reset_buses got=%h exp=0000", {dac_sel, result});
    end
    @(negedge clk); rstn = 1'b1;
  endtask

  task automatic test_basic;
    run_conv(8'hA5, 4'd2, 1'b0);
    checks++;
    if (result !== 8'hA5) begin failures++; $display("FAIL t1_result got=%h exp=a5", result); end
    checks++;
    if (rv_edge !== 18) begin failures++; $display("FAIL t1_latency got=%0d exp=18", rv_edge); end
    checks++;
    if (nsamp !== 2) begin failures++; $display("FAIL t1_sample_len got=%0d exp=2", nsamp); end
    checks++;
    if (ntrig !== 8) begin failures++; $display("FAIL t1_trig_count got=%0d exp=8", ntrig); end
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (trig_edge[k] !== 2 + 2 * k) begin
        failures++;
        $display("FAIL t1_trig_edge[%0d] got=%0d exp=%0d", k, trig_edge[k], 2 + 2 * k);
      end
    end
    @(posedge clk); #1;
    checks++;
    if (result_valid !== 1'b0 || result !== 8'hA5) begin
      failures++;
      $display("FAIL t1_pulse_hold got rv=%b res=%h exp rv=0 res=a5", result_valid, result);
    end
  endtask

  task automatic test_extremes;
    logic [7:0] exp_trial;
    run_conv(8'h00, 4'd2, 1'b0);
    checks++;
    if (result !== 8'h00) begin failures++; $display("FAIL t2_result00 got=%h exp=00", result); end
    checks++;
    if (dac_sel !== 8'h00 || busy !== 1'b0) begin
      failures++;
      $display("FAIL t2_done_state got dac=%h busy=%b exp dac=00 busy=0", dac_sel, busy);
    end
    for (int k = 0; k < 8; k++) begin
      exp_trial = 8'h80 >> k;
      checks++;
      if (trial[k] !== exp_trial) begin
        failures++;
        $display("FAIL t2_trial[%0d] got=%h exp=%h", k, trial[k], exp_trial);
      end
    end
    run_conv(8'hFF, 4'd2, 1'b0);
    checks++;
    if (result !== 8'hFF) begin failures++; $display("FAIL t2_resultff got=%h exp=ff", result); end
    checks++;
    if (timeout_err !== 1'b0) begin failures++; $display("FAIL t2_no_timeout got=%b exp=0", timeout_err); end
  endtask

  task automatic test_timeout;
    hold_msb = 1'b1;
    run_conv(8'hFF, 4'd2, 1'b0);
    hold_msb = 1'b0;
    checks++;
    if (result !== 8'h7F) begin failures++; $display("FAIL t3_result got=%h exp=7f", result); end
    checks++;
    if (timeout_err !== 1'b1) begin failures++; $display("FAIL t3_err_set got=%b exp=1", timeout_err); end
    checks++;
    if (rv_edge !== 32) begin failures++; $display("FAIL t3_latency got=%0d exp=32", rv_edge); end
    checks++;
    if (trig_edge[1] - trig_edge[0] !== 16) begin
      failures++;
      $display("FAIL t3_msb_wait got=%0d exp=16", trig_edge[1] - trig_edge[0]);
    end
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (timeout_err !== 1'b1) begin failures++; $display("FAIL t3_err_sticky got=%b exp=1", timeout_err); end
    run_conv(8'h3C, 4'd2, 1'b0);
    checks++;
    if (te_after !== 1'b0) begin failures++; $display("FAIL t3_err_clear got=%b exp=0", te_after); end
    checks++;
    if (result !== 8'h3C) begin failures++; $display("FAIL t3_next_result got=%h exp=3c", result); end
  endtask

  task automatic test_abort;
    logic seen_rv;
    logic seen_busy;
    vin = 8'hA5;
    sample_cycles = 4'd2;
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (sample !== 1'b0 || comp_trig !== 1'b1) begin
      failures++;
      $display("FAIL t4_busy_start_ignored got sample=%b trig=%b exp sample=0 trig=1", sample, comp_trig);
    end
    repeat (6) @(posedge clk);
    #1;
    checks++;
    if (dac_sel !== 8'hB0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL t4_pre_abort got dac=%h busy=%b exp dac=b0 busy=1", dac_sel, busy);
    end
    @(negedge clk); abort = 1'b1;
    @(posedge clk); #1; abort = 1'b0;
    checks++;
    if ({busy, sample, comp_trig, result_valid} !== 4'b0 || dac_sel !== 8'h00) begin
      failures++;
      $display("FAIL t4_abort_state got flags=%b dac=%h exp flags=0000 dac=00",
               {busy, sample, comp_trig, result_valid}, dac_sel);
    end
    checks++;
    if (result !== 8'h3C) begin failures++; $display("FAIL t4_result_kept got=%h exp=3c", result); end
    seen_rv = 1'b0;
    seen_busy = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (result_valid) seen_rv = 1'b1;
      if (busy) seen_busy = 1'b1;
    end
    checks++;
    if (seen_rv !== 1'b0 || seen_busy !== 1'b0) begin
      failures++;
      $display("FAIL t4_stays_idle got rv=%b busy=%b exp rv=0 busy=0", seen_rv, seen_busy);
    end
  endtask

  task automatic test_back_to_back;
    logic got;
    run_conv(8'h5A, 4'd0, 1'b1);
    checks++;
    if (nsamp !== 1) begin failures++; $display("FAIL t5_sample_len got=%0d exp=1", nsamp); end
    checks++;
    if (rv_edge !== 17) begin failures++; $display("FAIL t5_latency got=%0d exp=17", rv_edge); end
    checks++;
    if (result !== 8'h5A) begin failures++; $display("FAIL t5_result got=%h exp=5a", result); end
    @(posedge clk); #1;
    start = 1'b0;
    checks++;
    if (sample !== 1'b1 || busy !== 1'b1 || result_valid !== 1'b0) begin
      failures++;
      $display("FAIL t5_restart got sample=%b busy=%b rv=%b exp 1 1 0", sample, busy, result_valid);
    end
    vin = 8'hC3;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(posedge clk); #1;
      if (result_valid) got = 1'b1;
    end
    checks++;
    if (got !== 1'b1 || result !== 8'hC3) begin
      failures++;
      $display("FAIL t5_second_conv got done=%b res=%h exp done=1 res=c3", got, result);
    end
  endtask

  task automatic test_async_reset;
    vin = 8'h33;
    sample_cycles = 4'd3;
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b1 || comp_trig !== 1'b0 || dac_sel !== 8'h80) begin
      failures++;
      $display("FAIL t6_in_wait got busy=%b trig=%b dac=%h exp 1 0 80", busy, comp_trig, dac_sel);
    end
    #2 rstn = 1'b0;
    #1;
    checks++;
    if ({sample, comp_trig, busy, result_valid, timeout_err} !== 5'b0 || {dac_sel, result} !== 16'h0000) begin
      failures++;
      $display("FAIL t6_async_clear got flags=%b dac=%h res=%h exp all 0",
               {sample, comp_trig, busy, result_valid, timeout_err}, dac_sel, result);
    end
    @(negedge clk); rstn = 1'b1;
    run_conv(8'h33, 4'd3, 1'b0);
    checks++;
    if (result !== 8'h33 || rv_edge !== 19) begin
      failures++;
      $display("FAIL t6_fresh_conv got res=%h edge=%0d exp res=33 edge=19", result, rv_edge);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_extremes();
    test_timeout();
    test_abort();
    test_back_to_back();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
